// File: rtl/npxl_strang_treiber_if.sv
// Request / status / pixel-RAM bundle of the NeoPixel strand driver.
// master: frame requester + pixel RAM, slave: npxl_strang_treiber.
interface npxl_strang_treiber_if #(
    parameter int LEDS         = 20,
    parameter int BITS_PER_LED = 24
);
    localparam int AW = $clog2(LEDS);
    localparam int LW = $clog2(LEDS + 1);

    logic                    i_start;
    logic [LW-1:0]           i_len;
    logic [7:0]              i_brightness;
    logic [AW-1:0]           o_addr;
    logic [BITS_PER_LED-1:0] i_pixel;
    logic                    o_busy;
    logic                    o_done;

    modport master (
        output i_start, i_len, i_brightness, i_pixel,
        input  o_addr, o_busy, o_done
    );

    modport slave (
        input  i_start, i_len, i_brightness, i_pixel,
        output o_addr, o_busy, o_done
    );
endinterface

// File: rtl/npxl_strang_treiber.sv
// WS2812/SK6812 strand driver: streams len colour words from a pixel RAM.
// Ports: i_clk, i_rst (sync, high), bus (start/len/brightness, RAM, busy/done), o_npxl_data.
module npxl_strang_treiber #(
    parameter int LEDS         = 20,
    parameter int BITS_PER_LED = 24,
    parameter int T_BIT        = 60,
    parameter int T0H          = 20,
    parameter int T1H          = 40,
    parameter int T_RESET      = 3600
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    npxl_strang_treiber_if.slave bus,
    output logic                 o_npxl_data
);
    localparam int AW   = $clog2(LEDS);
    localparam int LW   = $clog2(LEDS + 1);
    localparam int BW   = $clog2(BITS_PER_LED);
    localparam int NCH  = BITS_PER_LED / 8;
    localparam int CMAX = (T_RESET > T_BIT) ? T_RESET : T_BIT;
    localparam int CW   = $clog2(CMAX);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_SEND,
        S_LATCH
    } state_t;

    state_t                  state, state_d;
    logic                    fetch_rdy;
    logic                    done_q;
    logic [CW-1:0]           cnt;
    logic [BW-1:0]           bit_idx;
    logic [LW-1:0]           led;
    logic [LW-1:0]           len_q;
    logic [LW-1:0]           len_in;
    logic [LW-1:0]           addr_nxt;
    logic [7:0]              bright_q;
    logic [AW-1:0]           addr_q;
    logic [BITS_PER_LED-1:0] shift_q;
    logic [BITS_PER_LED-1:0] shadow_q;
    logic                    start_ok;
    logic                    bit_end;
    logic                    last_bit;
    logic                    last_led;
    logic                    latch_end;

    // Per channel: (c * (bright + 1)) >> 8.
    function automatic logic [BITS_PER_LED-1:0] scale(
        input logic [BITS_PER_LED-1:0] px,
        input logic [7:0]              b
    );
        logic [15:0] p;
        scale = '0;
        for (int i = 0; i < NCH; i++) begin
            p = {8'd0, px[8*i +: 8]} * ({8'd0, b} + 16'd1);
            scale[8*i +: 8] = 8'(p >> 8);
        end
    endfunction

    assign len_in    = (bus.i_len > LW'(LEDS)) ? LW'(LEDS) : bus.i_len;
    // The o_done cycle is still part of the finished frame.
    assign start_ok  = (state == S_IDLE) && !done_q && bus.i_start;
    assign bit_end   = (cnt == CW'(T_BIT - 1));
    assign last_bit  = (bit_idx == BW'(BITS_PER_LED - 1));
    assign last_led  = (led == len_q - LW'(1));
    assign latch_end = (cnt == CW'(T_RESET - 1));
    // Prefetch target n+2, saturating at the last LED of the frame.
    assign addr_nxt  = (led + LW'(1) >= len_q - LW'(1)) ?
                       len_q - LW'(1) : led + LW'(2);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = (len_in == '0) ? S_LATCH : S_FETCH;
                end
            end
            S_FETCH: begin
                if (fetch_rdy) begin
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (bit_end && last_bit && last_led) begin
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                if (latch_end) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_npxl_data = 1'b0;
        if (state == S_SEND) begin
            o_npxl_data = cnt < (shift_q[BITS_PER_LED-1] ?
                                 CW'(T1H) : CW'(T0H));
        end
        bus.o_busy = (state != S_IDLE);
        bus.o_done = done_q;
        bus.o_addr = addr_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fetch_rdy <= 1'b0;
            done_q    <= 1'b0;
            cnt       <= '0;
            bit_idx   <= '0;
            led       <= '0;
            len_q     <= '0;
            bright_q  <= '0;
            addr_q    <= '0;
            shift_q   <= '0;
            shadow_q  <= '0;
        end else begin
            done_q    <= (state == S_LATCH) && latch_end;
            // First FETCH cycle covers the RAM read latency.
            fetch_rdy <= (state == S_FETCH) && !fetch_rdy;
            unique case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        len_q    <= len_in;
                        bright_q <= bus.i_brightness;
                        addr_q   <= '0;
                        led      <= '0;
                        cnt      <= '0;
                        bit_idx  <= '0;
                    end
                end
                S_FETCH: begin
                    if (fetch_rdy) begin
                        shift_q <= scale(bus.i_pixel, bright_q);
                        addr_q  <= (len_q > LW'(1)) ? AW'(1) : '0;
                        cnt     <= '0;
                        bit_idx <= '0;
                        led     <= '0;
                    end
                end
                S_SEND: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (last_bit) begin
                            bit_idx <= '0;
                            led     <= led + LW'(1);
                            shift_q <= shadow_q;
                        end else begin
                            bit_idx <= bit_idx + BW'(1);
                            shift_q <= shift_q << 1;
                        end
                        // Word for LED n+1 has been on i_pixel for most of bit 0.
                        if (bit_idx == '0) begin
                            shadow_q <= scale(bus.i_pixel, bright_q);
                            addr_q   <= AW'(addr_nxt);
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_LATCH: begin
                    cnt <= latch_end ? '0 : cnt + CW'(1);
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_npxl_strang_treiber.sv
// Directed bench for npxl_strang_treiber: RGB and RGBW instances,
// decodes the strand waveform bit by bit and checks timing and handshake.
module tb_npxl_strang_treiber;
    localparam int T_BIT   = 60;
    localparam int T0H     = 20;
    localparam int T1H     = 40;
    localparam int T_RESET = 3600;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic data24;
    logic data32;
    int   total = 0;
    int   bad = 0;
    int   busy_cnt = 0;
    logic [23:0] ram24 [0:19];
    logic [31:0] ram32 [0:19];
    logic [4:0]  addr_prev = '0;
    int          addr_log[$];

    always #5 clk = ~clk;

    npxl_strang_treiber_if #(.LEDS(20), .BITS_PER_LED(24)) bus24 ();
    npxl_strang_treiber_if #(.LEDS(20), .BITS_PER_LED(32)) bus32 ();

    npxl_strang_treiber #(.LEDS(20), .BITS_PER_LED(24)) dut24 (
        .i_clk       (clk),
        .i_rst       (rst),
        .bus         (bus24),
        .o_npxl_data (data24)
    );

    npxl_strang_treiber #(.LEDS(20), .BITS_PER_LED(32)) dut32 (
        .i_clk       (clk),
        .i_rst       (rst),
        .bus         (bus32),
        .o_npxl_data (data32)
    );

    always @(posedge clk) bus24.i_pixel <= ram24[bus24.o_addr];
    always @(posedge clk) bus32.i_pixel <= ram32[bus32.o_addr];

    always @(negedge clk) begin
        if (bus24.o_busy === 1'b1) busy_cnt++;
        if (bus24.o_addr !== addr_prev) begin
            addr_log.push_back(int'(bus24.o_addr));
            addr_prev = bus24.o_addr;
        end
    end

    task automatic chk(input string tag, input logic [95:0] obs,
                       input logic [95:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rx_bits(input bit sel, input int n, output int badp,
                           output logic [95:0] w);
        int  hi;
        bit  low;
        bit  shape;
        badp = 0;
        w = '0;
        for (int b = 0; b < n; b++) begin
            hi = 0;
            low = 1'b0;
            shape = 1'b1;
            for (int c = 0; c < T_BIT; c++) begin
                if ((sel ? data32 : data24) === 1'b1) begin
                    hi++;
                    if (low) shape = 1'b0;
                end else begin
                    low = 1'b1;
                end
                @(negedge clk);
            end
            if (!shape || (hi != T0H && hi != T1H)) badp++;
            w = {w[94:0], (hi == T1H)};
        end
    endtask

    task automatic wait_done(input bit sel, input int bound, output int lat,
                             output int hi, output bit got);
        lat = 0;
        hi = 0;
        got = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if ((sel ? bus32.o_done : bus24.o_done) === 1'b1) begin
                got = 1'b1;
                break;
            end
            if ((sel ? data32 : data24) === 1'b1) hi++;
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic start24(input int len, input logic [7:0] br);
        bus24.i_start = 1'b1;
        bus24.i_len = 5'(len);
        bus24.i_brightness = br;
        @(negedge clk);
        bus24.i_start = 1'b0;
        bus24.i_len = 5'd7;
        bus24.i_brightness = 8'h00;
    endtask

    task automatic run24(input string tag, input int len,
                         input logic [7:0] br, input int nbits,
                         input logic [95:0] expw);
        int          badp;
        int          lat;
        int          hi;
        bit          got;
        logic [95:0] w;
        start24(len, br);
        chk({tag, ".busy"}, 96'(bus24.o_busy), 96'd1);
        @(negedge clk);
        chk({tag, ".pre"}, 96'(data24), 96'd0);
        @(negedge clk);
        chk({tag, ".rise"}, 96'(data24), 96'd1);
        rx_bits(1'b0, nbits, badp, w);
        chk({tag, ".periods"}, 96'(badp), 96'd0);
        chk({tag, ".word"}, w, expw);
        wait_done(1'b0, T_RESET + 100, lat, hi, got);
        chk({tag, ".done"}, 96'(got), 96'd1);
        chk({tag, ".latch"}, 96'(lat), 96'(T_RESET));
        chk({tag, ".latchlow"}, 96'(hi), 96'd0);
        @(negedge clk);
        chk({tag, ".pulse"}, 96'(bus24.o_done), 96'd0);
        chk({tag, ".idle"}, 96'(bus24.o_busy), 96'd0);
    endtask

    initial begin
        int          badp;
        int          lat;
        int          hi;
        int          dcnt;
        int          hcnt;
        bit          got;
        logic [95:0] w;

        bus24.i_start = 1'b0;
        bus24.i_len = '0;
        bus24.i_brightness = '0;
        bus32.i_start = 1'b0;
        bus32.i_len = '0;
        bus32.i_brightness = '0;
        for (int i = 0; i < 20; i++) begin
            ram24[i] = '0;
            ram32[i] = '0;
        end

        repeat (3) @(negedge clk);
        chk("rst.busy", 96'(bus24.o_busy), 96'd0);
        chk("rst.done", 96'(bus24.o_done), 96'd0);
        chk("rst.addr", 96'(bus24.o_addr), 96'd0);
        chk("rst.line", 96'(data24), 96'd0);
        chk("rst.line32", 96'(data32), 96'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single LED, full brightness, 2+1440+3600 busy cycles.
        ram24[0] = 24'hA50000;
        busy_cnt = 0;
        run24("one", 1, 8'hFF, 24, 96'hA50000);
        chk("one.busycycles", 96'(busy_cnt), 96'(2 + 1440 + T_RESET));

        // Three LEDs back to back; address walk 0,1,2 then hold.
        ram24[0] = 24'hFFFFFF;
        ram24[1] = 24'h000000;
        ram24[2] = 24'h0F0F0F;
        addr_log.delete();
        run24("three", 3, 8'hFF, 72, 96'hFFFFFF0000000F0F0F);
        chk("three.naddr", 96'(addr_log.size()), 96'd2);
        chk("three.addr1", 96'(addr_log[0]), 96'd1);
        chk("three.addr2", 96'(addr_log[1]), 96'd2);
        chk("three.hold", 96'(bus24.o_addr), 96'd2);

        // Empty frame: straight to latch.
        start24(0, 8'hFF);
        chk("zero.busy", 96'(bus24.o_busy), 96'd1);
        wait_done(1'b0, T_RESET + 100, lat, hi, got);
        chk("zero.done", 96'(got), 96'd1);
        chk("zero.latch", 96'(lat), 96'(T_RESET));
        chk("zero.nohigh", 96'(hi), 96'd0);
        @(negedge clk);

        // Abort in the middle of LED 1.
        start24(3, 8'hFF);
        repeat (2 + 24 * T_BIT + 12 * T_BIT) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort.line", 96'(data24), 96'd0);
        chk("abort.busy", 96'(bus24.o_busy), 96'd0);
        rst = 1'b0;
        dcnt = 0;
        hcnt = 0;
        for (int i = 0; i < 200; i++) begin
            if (bus24.o_done === 1'b1) dcnt++;
            if (data24 === 1'b1) hcnt++;
            @(negedge clk);
        end
        chk("abort.nodone", 96'(dcnt), 96'd0);
        chk("abort.quiet", 96'(hcnt), 96'd0);

        // Clean frame after abort, with brightness scaling.
        ram24[0] = 24'hFF8001;
        run24("bright", 1, 8'd127, 24, 96'h7F4000);

        // Oversized request clamps to 20 LEDs.
        for (int i = 0; i < 20; i++) ram24[i] = {3{8'(i + 1)}};
        run24("clamp", 25, 8'hFF, 480, 96'h111111121212131313141414);

        // RGBW: start held high through the frame and the o_done cycle.
        ram32[0] = 32'h80FF0155;
        ram32[1] = 32'h00A5C3FF;
        bus32.i_start = 1'b1;
        bus32.i_len = 5'd2;
        bus32.i_brightness = 8'hFF;
        @(negedge clk);
        chk("w.busy", 96'(bus32.o_busy), 96'd1);
        @(negedge clk);
        chk("w.pre", 96'(data32), 96'd0);
        @(negedge clk);
        chk("w.rise", 96'(data32), 96'd1);
        rx_bits(1'b1, 64, badp, w);
        chk("w.periods", 96'(badp), 96'd0);
        chk("w.word", w, 96'h80FF015500A5C3FF);
        wait_done(1'b1, T_RESET + 100, lat, hi, got);
        chk("w.done", 96'(got), 96'd1);
        chk("w.latch", 96'(lat), 96'(T_RESET));
        @(negedge clk);
        chk("w.ignored", 96'(bus32.o_busy), 96'd0);
        @(negedge clk);
        bus32.i_start = 1'b0;
        chk("w.relaunch", 96'(bus32.o_busy), 96'd1);
        @(negedge clk);
        @(negedge clk);
        chk("w2.rise", 96'(data32), 96'd1);
        rx_bits(1'b1, 64, badp, w);
        chk("w2.periods", 96'(badp), 96'd0);
        chk("w2.word", w, 96'h80FF015500A5C3FF);
        wait_done(1'b1, T_RESET + 100, lat, hi, got);
        chk("w2.done", 96'(got), 96'd1);
        chk("w2.latchlow", 96'(hi), 96'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/npxl_strang_treiber.md
Name: npxl_strang_treiber

Overview:
- Parametrised second-generation NeoPixel (WS2812/SK6812) serial driver. It streams a frame of LED colour words from an external synchronous pixel RAM to one data pin.
- Adds configurable pulse timing, RGB or RGBW word width, runtime strand length, global brightness scaling, a start/busy/done handshake and seamless prefetch, so there are no stretched bits between LEDs.
- Sits between the VU level-to-colour logic (which fills the pixel RAM) and the strand output pin.

Parameters:
- LEDS, 20, maximum LEDs per strand; sets the address width AW = $clog2(LEDS).
- BITS_PER_LED, 24, colour word width; legal values are 24 (GRB) and 32 (GRBW). Organised as 8-bit channels, MSB first.
- T_BIT, 60, bit period in clock cycles (1.25 us at 48 MHz).
- T0H, 20, high time of a 0 bit in cycles; must be less than T1H.
- T1H, 40, high time of a 1 bit in cycles; must be less than T_BIT.
- T_RESET, 3600, low latch time after the last bit, in cycles (75 us).

Ports:
- i_clk  in  1  system clock (48 MHz)
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  frame request; sampled only in IDLE
- i_len  in  $clog2(LEDS+1)  LEDs in this frame; sampled with i_start
- i_brightness  in  8  global brightness; sampled with i_start
- o_addr  out  AW  pixel RAM read address
- i_pixel  in  BITS_PER_LED  pixel RAM read data; 1-cycle read latency
- o_npxl_data  out  1  strand data line
- o_busy  out  1  high from the cycle after start acceptance until the frame completes
- o_done  out  1  one-cycle pulse when the latch period ends

Behaviour:
- Reset (i_rst high at an edge): state IDLE; o_npxl_data=0, o_busy=0, o_done=0, o_addr=0; all counters cleared. Reset mid-frame aborts immediately: the line drops low on that edge and no o_done is issued.
- States are IDLE, FETCH, SEND, LATCH.
- IDLE:
  - o_npxl_data=0.
  - When i_start=1 at edge E0, the block latches len=min(i_len, LEDS) and bright=i_brightness.
  - It sets o_addr=0, o_busy=1 and goes to FETCH.
  - If len=0 it goes directly to LATCH instead (busy, no bits sent).
- FETCH:
  - Waits one cycle for RAM latency.
  - At edge E2 it loads the shift register with scale(i_pixel), sets o_addr=1 (or holds it if len=1) and drives o_npxl_data=1.
  - It then enters SEND. The first rising edge of the line therefore appears 2 cycles after start acceptance.
- scale():
  - Each 8-bit channel c becomes (c*(bright+1))>>8, using a 16-bit intermediate.
  - bright=255 gives identity; bright=0 yields 0 for every channel.
- SEND:
  - Each bit lasts exactly T_BIT cycles, counted 0..T_BIT-1.
  - The line is high while count < T0H for a 0 bit, or count < T1H for a 1 bit, and low otherwise.
  - Bits go out MSB first.
- Prefetch:
  - During the first bit of LED n, the block captures i_pixel for address n+1 into a shadow register and advances o_addr to n+2, saturating at len-1.
  - At the end of the last bit of LED n, the shift register loads the shadow. The next bit starts on the following cycle with no gap.
  - The total frame is exactly len*BITS_PER_LED*T_BIT cycles of SEND.
- After the last bit of LED len-1: go to LATCH with the line low.
- LATCH:
  - Holds the line low for exactly T_RESET cycles.
  - On the final edge it pulses o_done=1 for one cycle, sets o_busy=0 and returns to IDLE.
- Handshake rules:
  - i_start while o_busy=1, including the o_done cycle, is ignored and not queued.
  - i_start in the first cycle after o_done is accepted.
  - i_len, i_brightness and i_pixel changes outside their sampling cycles have no effect on the frame in flight.
- Wrap/clamp: o_addr never exceeds len-1; i_len>LEDS is clamped to LEDS.

Test Plan:
- Defaults, i_len=1, i_brightness=255, RAM[0]=24'hA50000 -> line rises 2 cycles after start; bits 1,0,1,0,0,1,0,1 are 40/20/40/20/20/40/20/40 cycles high in 60-cycle periods, followed by 16 zero bits; then 3600 low cycles; o_done pulses once; total o_busy time is 1440+3600+2 cycles.
- i_len=3, RAM[0..2] = FFFFFF, 000000, 0F0F0F -> 72 contiguous bit periods, each exactly 60 cycles, with no gap at LED boundaries; o_addr sequence is 0, 1, 2 and then holds at 2.
- i_brightness=127, RAM[0]=24'hFF8001 -> transmitted word is 7F4000, since (255*128)>>8=127, (128*128)>>8=64 and (1*128)>>8=0.
- BITS_PER_LED=32, i_len=2 -> 64 bits are sent; i_start pulses during the frame and during the o_done cycle are ignored; a start on the cycle after o_done launches a new frame.
- i_len=0 -> no high pulses; o_done arrives after 3600 LATCH cycles. i_len=25 with LEDS=20 -> exactly 20 LEDs are sent.
- i_rst asserted in the middle of LED 1 -> o_npxl_data=0 and o_busy=0 on the next edge, no o_done; a subsequent start runs a clean frame from address 0.
